// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: shares one RAM port between CPUS cores with snoop-based coherence
module snoop_bus_arbiter #(
    parameter int CPUS  = 2,
    parameter int WORDS = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    output logic [CPUS-1:0]      iwait,
    input  logic [CPUS*AW-1:0]   iaddr,
    output logic [CPUS*DW-1:0]   iload,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*AW-1:0]   daddr,
    input  logic [CPUS*DW-1:0]   dstore,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*DW-1:0]   dload,
    input  logic [CPUS-1:0]      cctrans,
    input  logic [CPUS-1:0]      ccwrite,
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output logic [CPUS*AW-1:0]   ccsnoopaddr,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [AW-1:0]        ramaddr,
    output logic [DW-1:0]        ramstore,
    input  logic [DW-1:0]        ramload,
    input  logic [1:0]           ramstate
);
    localparam int PW = $clog2(CPUS);
    localparam int CW = $clog2(WORDS) + 1;

    typedef enum logic [2:0] {IDLE, ARB, DWB, SNOOP, C2C, MEMRD, IFETCH} state_t;

    state_t          state, nstate;
    logic [PW-1:0]   dptr, iptr, win, igr, sup, nwin, nigr, nsup, idx;
    logic [CW-1:0]   wcnt;
    logic [CPUS-1:0] dreq, others;
    logic            acc, last, dfound, ifound, sfound, alldone;

    assign acc  = ramstate == 2'd2;
    assign last = wcnt == CW'(WORDS - 1);

    // round-robin winners, non-winner mask, snoop completion and supplier pick
    always_comb begin
        dreq   = dWEN | cctrans;
        nwin   = dptr;
        nigr   = iptr;
        dfound = 1'b0;
        ifound = 1'b0;
        idx    = '0;
        for (int k = CPUS; k >= 1; k--) begin
            idx = PW'((int'(dptr) + k) % CPUS);
            if (dreq[idx]) begin
                nwin   = idx;
                dfound = 1'b1;
            end
            idx = PW'((int'(iptr) + k) % CPUS);
            if (iREN[idx]) begin
                nigr   = idx;
                ifound = 1'b1;
            end
        end
        others  = ~(CPUS'(1) << win);
        alldone = &(cctrans | ~others);
        nsup    = '0;
        sfound  = 1'b0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (others[j] && ccwrite[j]) begin
                nsup   = PW'(j);
                sfound = 1'b1;
            end
        end
    end

    // next-state and per-state bus steering; everything idles at defaults
    always_comb begin
        nstate      = state;
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        case (state)
            IDLE: nstate = |{iREN, dREN, dWEN, cctrans} ? ARB : IDLE;
            ARB: nstate = dfound ? (dWEN[nwin] ? DWB : SNOOP) : (ifound ? IFETCH : IDLE);
            DWB: begin
                ramWEN     = 1'b1;
                ramaddr    = daddr[win*AW +: AW];
                ramstore   = dstore[win*DW +: DW];
                dwait[win] = ~acc;
                nstate     = acc && last ? IDLE : DWB;
            end
            SNOOP: begin
                ccwait = others;
                ccinv  = ccwrite[win] ? others : '0;
                for (int j = 0; j < CPUS; j++) begin
                    if (others[j]) ccsnoopaddr[j*AW +: AW] = daddr[win*AW +: AW];
                end
                if (alldone) nstate = !(dREN[win] || dWEN[win]) ? IDLE : (sfound ? C2C : MEMRD);
            end
            C2C: begin
                ramWEN             = 1'b1;
                ramaddr            = daddr[win*AW +: AW];
                ramstore           = dstore[sup*DW +: DW];
                dload[win*DW +: DW] = dstore[sup*DW +: DW];
                dwait[win]         = ~acc;
                dwait[sup]         = ~acc;
                ccwait             = others;
                nstate             = acc && last ? IDLE : C2C;
            end
            MEMRD: begin
                ramREN             = 1'b1;
                ramaddr            = daddr[win*AW +: AW];
                dload[win*DW +: DW] = ramload;
                dwait[win]         = ~acc;
                ccwait             = others;
                nstate             = acc && last ? IDLE : MEMRD;
            end
            IFETCH: begin
                ramREN             = 1'b1;
                ramaddr            = iaddr[igr*AW +: AW];
                iload[igr*DW +: DW] = ramload;
                iwait[igr]         = ~acc;
                nstate             = acc ? IDLE : IFETCH;
            end
            default: nstate = IDLE;
        endcase
    end

    // state, grant pointers, latched winners and beat counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            wcnt  <= '0;
            dptr  <= PW'(CPUS - 1);
            iptr  <= PW'(CPUS - 1);
            win   <= '0;
            igr   <= '0;
            sup   <= '0;
        end else begin
            state <= nstate;
            if (state == ARB) begin
                wcnt <= '0;
                if (dfound) begin
                    dptr <= nwin;
                    win  <= nwin;
                end else if (ifound) begin
                    iptr <= nigr;
                    igr  <= nigr;
                end
            end else if (acc && (state == DWB || state == C2C || state == MEMRD || state == IFETCH)) begin
                wcnt <= wcnt + 1'b1;
            end
            if (state == SNOOP && alldone) sup <= nsup;
        end
    end
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: randomized transaction-level check of snoop_bus_arbiter
module tb_snoop_bus_arbiter;
    localparam int C  = 4;
    localparam int W  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            CLK, nRST;
    logic [C-1:0]    iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
    logic [C*AW-1:0] iaddr, daddr, ccsnoopaddr;
    logic [C*DW-1:0] iload, dload, dstore;
    logic            ramREN, ramWEN;
    logic [AW-1:0]   ramaddr;
    logic [DW-1:0]   ramstore, ramload;
    logic [1:0]      ramstate;

    int          checks = 0;
    int          errors = 0;
    int          dptr = C - 1;
    int          iptr = C - 1;
    logic [3:0]  obs_ccwait;
    logic [1:0]  script[$];
    bit          force_acc = 0;

    snoop_bus_arbiter #(.CPUS(C), .WORDS(W), .AW(AW), .DW(DW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iwait(iwait), .iaddr(iaddr), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr(input int lastg, input logic [3:0] m);
        for (int k = 1; k <= C; k++) if (m[(lastg + k) % C]) return (lastg + k) % C;
        return lastg;
    endfunction

    function automatic logic [127:0] slot(input int i, input logic [31:0] v);
        return {96'b0, v} << (i * 32);
    endfunction

    function automatic logic [1:0] pick();
        if (script.size() > 0) return script.pop_front();
        if (force_acc) return 2'd2;
        return $urandom_range(0, 1) ? 2'd2 : 2'($urandom_range(0, 3));
    endfunction

    task automatic check_outs(input string tag, input logic [3:0] eiw, edw,
                              input logic [127:0] eil, edl, input logic er, ew,
                              input logic [31:0] ea, es, input logic [3:0] ecw, eci,
                              input logic [127:0] esa);
        check({tag, ".iwait"}, 128'(iwait), 128'(eiw));
        check({tag, ".dwait"}, 128'(dwait), 128'(edw));
        check({tag, ".iload"}, iload, eil);
        check({tag, ".dload"}, dload, edl);
        check({tag, ".ramREN"}, 128'(ramREN), 128'(er));
        check({tag, ".ramWEN"}, 128'(ramWEN), 128'(ew));
        check({tag, ".ramaddr"}, 128'(ramaddr), 128'(ea));
        check({tag, ".ramstore"}, 128'(ramstore), 128'(es));
        check({tag, ".ccwait"}, 128'(ccwait), 128'(ecw));
        check({tag, ".ccinv"}, 128'(ccinv), 128'(eci));
        check({tag, ".snoopaddr"}, ccsnoopaddr, esa);
    endtask

    task automatic check_default(input string tag);
        check_outs(tag, '1, '1, '0, '0, 0, 0, '0, '0, '0, '0, '0);
    endtask

    task automatic clear_in(input bit keep_i);
        dWEN = '0; dREN = '0; cctrans = '0; ccwrite = '0;
        if (!keep_i) iREN = '0;
    endtask

    task automatic rand_data();
        daddr  = {$urandom, $urandom, $urandom, $urandom};
        iaddr  = {$urandom, $urandom, $urandom, $urandom};
        dstore = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // kinds: 0 writeback, 1 snoop, 2 ifetch, 3 cache-to-cache, 4 memory read, 5 upgrade done
    task automatic run_txn(input logic [3:0] dw, ct, ir, input int rdel, input int cw_in,
                           input bit upg, input int rst_beat, input bit keep_i);
        int w, ig, s, kind, beats, c;
        logic [3:0] cw, oth, edw, eiw;
        logic [127:0] sa, edl, eil;
        logic acc;
        w = 0; ig = 0; s = 0;
        if ((dw | ct) != 0) begin
            w = rr(dptr, dw | ct); dptr = w; kind = dw[w] ? 0 : 1;
        end else begin
            ig = rr(iptr, ir); iptr = ig; kind = 2;
        end
        cw = cw_in < 0 ? 4'($urandom) : 4'(cw_in);
        if (rdel < 0) rdel = $urandom_range(0, 3);
        oth = ~(4'b1 << w);
        dWEN = dw; cctrans = ct; iREN = ir; dREN = ct; ccwrite = '0;
        @(negedge CLK);
        ramstate = 2'($urandom); #1;
        check_default("arb");
        @(negedge CLK);
        if (kind == 1) begin
            sa = '0;
            for (int j = 0; j < C; j++) if (oth[j]) sa |= slot(j, daddr[w*AW +: AW]);
            dWEN = '0; iREN = keep_i ? ir : '0;
            dREN = upg ? 4'b0 : (4'b1 << w);
            cctrans = rdel == 0 ? oth : '0;
            ccwrite = cw;
            for (c = 0; c < 8; c++) begin
                ramstate = 2'($urandom); #1;
                check_outs("snoop", '1, '1, '0, '0, 0, 0, '0, '0, oth, cw[w] ? oth : 4'b0, sa);
                if (c == 0) obs_ccwait = ccwait;
                if (c == rdel) break;
                @(negedge CLK);
                cctrans = (c + 1 == rdel) ? oth : '0;
            end
            @(negedge CLK);
            cctrans = '0; ccwrite = '0; dREN = '0;
            if (upg) kind = 5;
            else if ((cw & oth) != 0) begin
                kind = 3;
                for (int j = C - 1; j >= 0; j--) if (cw[j] && oth[j]) s = j;
            end else kind = 4;
        end else clear_in(keep_i);
        if (kind != 5) begin
            beats = 0;
            for (c = 0; c < 64; c++) begin
                ramstate = pick(); ramload = $urandom;
                acc = ramstate == 2'd2;
                #1;
                edw = '1; eiw = '1; edl = '0; eil = '0;
                case (kind)
                    0: begin
                        edw[w] = ~acc;
                        check_outs("dwb", eiw, edw, eil, edl, 0, 1, daddr[w*AW +: AW],
                                   dstore[w*DW +: DW], '0, '0, '0);
                    end
                    3: begin
                        edw[w] = ~acc; edw[s] = ~acc;
                        edl = slot(w, dstore[s*DW +: DW]);
                        check_outs("c2c", eiw, edw, eil, edl, 0, 1, daddr[w*AW +: AW],
                                   dstore[s*DW +: DW], oth, '0, '0);
                    end
                    4: begin
                        edw[w] = ~acc; edl = slot(w, ramload);
                        check_outs("memrd", eiw, edw, eil, edl, 1, 0, daddr[w*AW +: AW],
                                   '0, oth, '0, '0);
                    end
                    default: begin
                        eiw[ig] = ~acc; eil = slot(ig, ramload);
                        check_outs("ifetch", eiw, edw, eil, edl, 1, 0, iaddr[ig*AW +: AW],
                                   '0, '0, '0, '0);
                    end
                endcase
                if (rst_beat >= 0 && beats == rst_beat) begin
                    nRST = 0; #1;
                    check_default("async_rst");
                    clear_in(0);
                    @(negedge CLK);
                    nRST = 1;
                    dptr = C - 1; iptr = C - 1;
                    return;
                end
                if (acc) beats++;
                if (beats == (kind == 2 ? 1 : W)) break;
                @(negedge CLK);
            end
            if (c == 64) check("beat_timeout", 128'(beats), 128'(kind == 2 ? 1 : W));
            @(negedge CLK);
        end
        clear_in(keep_i);
        ramstate = 2'($urandom); #1;
        check_default("done");
    endtask

    initial begin
        nRST = 0;
        clear_in(0);
        ramstate = 2'd2; ramload = '0;
        rand_data();
        repeat (3) begin
            @(negedge CLK); #1;
            check_default("reset");
        end
        iREN = 4'b1111; dWEN = 4'b1111; #1;
        check_default("reset_req");
        clear_in(0);
        @(negedge CLK);
        nRST = 1;
        // writeback on cache 0 then instruction fetch for core 1, RAM always ready
        force_acc = 1;
        run_txn(4'b0001, 4'b0000, 4'b0010, -1, -1, 0, -1, 1);
        run_txn(4'b0000, 4'b0000, 4'b0010, -1, -1, 0, -1, 0);
        // cache 1 supplies a dirty block to cache 0 after three snoop cycles
        rand_data();
        dstore[63:32] = 32'hDEADBEEF;
        run_txn(4'b0000, 4'b0001, 4'b0000, 3, 4'b0010, 0, -1, 0);
        force_acc = 0;
        // memory read through BUSY, ACCESS, ERROR, ACCESS
        rand_data();
        script = '{2'd1, 2'd2, 2'd3, 2'd2};
        run_txn(4'b0000, 4'b0100, 4'b0000, 0, 0, 0, -1, 0);
        // reset in second beat of a cache-to-cache transfer, then first grant is cache 0
        force_acc = 1;
        rand_data();
        run_txn(4'b0000, 4'b0010, 4'b0000, 0, 4'b0001, 0, 1, 0);
        run_txn(4'b1111, 4'b0000, 4'b0000, -1, -1, 0, -1, 0);
        force_acc = 0;
        // caches 1 and 3 competing repeatedly must alternate
        for (int i = 0; i < 4; i++) begin
            rand_data();
            run_txn(4'b0000, 4'b1010, 4'b0000, -1, 0, 0, -1, 0);
            check("rr_alternate", 128'(obs_ccwait), 128'(i % 2 ? 4'b0111 : 4'b1101));
        end
        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            logic [3:0] dw, ct, ir;
            rand_data();
            dw = $urandom_range(0, 1) ? 4'($urandom) : 4'b0;
            ct = $urandom_range(0, 1) ? 4'($urandom) : 4'b0;
            ir = $urandom_range(0, 1) ? 4'($urandom) : 4'b0;
            if ((dw | ct | ir) == 0) ir = 4'b1 << $urandom_range(0, 3);
            run_txn(dw, ct, ir, -1, -1, $urandom_range(0, 3) == 0, -1, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/snoop_bus_arbiter.md
SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

Interface
REQ-001 Parameter CPUS, default 2, number of caches/cores sharing one RAM port; legal range 2..8.
REQ-002 Parameter WORDS, default 2, words per coherence block transfer; legal range 1..8.
REQ-003 Parameter AW, default 32, address width; DW, default 32, data width.
REQ-004 CLK  in  1  single clock, all state updates on rising edge.
REQ-005 nRST  in  1  reset, asynchronous, active-low.
REQ-006 iREN/iwait  in/out  CPUS  per-core instruction read request / stall.
REQ-007 iaddr/iload  in/out  CPUS*AW / CPUS*DW  per-core instruction address / returned word.
REQ-008 dREN, dWEN  in  CPUS  per-cache data read / writeback request.
REQ-009 daddr, dstore  in  CPUS*AW, CPUS*DW  per-cache data address / store word.
REQ-010 dwait/dload  out  CPUS / CPUS*DW  per-cache data stall / returned word.
REQ-011 cctrans, ccwrite  in  CPUS  cache coherence transaction request (requester) or snoop-done (snooped cache); intent-to-modify (requester) or dirty-hit (snooped cache).
REQ-012 ccwait, ccinv  out  CPUS  per-cache snoop hold / invalidate.
REQ-013 ccsnoopaddr  out  CPUS*AW  per-cache snoop address.
REQ-014 ramREN, ramWEN  out  1  RAM read / write strobe, never both high.
REQ-015 ramaddr/ramstore/ramload  out/out/in  AW/DW/DW  RAM address, write data, read data.
REQ-016 ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-017 States: IDLE, ARB, DWB, SNOOP, C2C, MEMRD, IFETCH; word counter wcnt of width clog2(WORDS)+1.
REQ-018 IDLE -> ARB when any iREN, dREN, dWEN or cctrans bit is high; otherwise hold.
REQ-019 ARB shall grant data side (dWEN or cctrans) over instruction side; data winner by round-robin starting at (last data grant + 1) mod CPUS; instruction winner by independent round-robin pointer.
REQ-020 Grant pointers update only on grant in ARB; each pointer holds its value during a transaction.
REQ-021 ARB -> DWB if winner has dWEN; -> SNOOP if winner has cctrans; -> IFETCH if instruction grant only; wcnt cleared on every ARB exit.
REQ-022 DWB: ramWEN=1, ramaddr/ramstore from winner; dwait[winner]=0 for exactly the cycles ramstate==ACCESS; wcnt increments per ACCESS; -> IDLE when wcnt reaches WORDS.
REQ-023 SNOOP: ccwait=1 and ccsnoopaddr=daddr[winner] on every non-winner; ccinv[j]=ccwrite[winner] for every non-winner j; no RAM strobe.
REQ-024 SNOOP exits only when every non-winner has cctrans high in the same cycle; if any has ccwrite high -> C2C with supplier = lowest such index; else -> MEMRD.
REQ-025 SNOOP exit when winner dropped dREN and dWEN (upgrade-only miss): -> IDLE, no RAM access.
REQ-026 C2C: dload[winner]=dstore[supplier]; ramWEN=1, ramaddr=daddr[winner], ramstore=dstore[supplier]; dwait[winner] and dwait[supplier]=0 on ACCESS; ccwait held on non-winners; WORDS beats then IDLE.
REQ-027 MEMRD: ramREN=1, ramaddr=daddr[winner], dload[winner]=ramload, dwait[winner]=0 on ACCESS; ccwait held; WORDS beats then IDLE.
REQ-028 IFETCH: ramREN=1, ramaddr=iaddr[igrant], iload[igrant]=ramload, iwait[igrant]=0 on ACCESS; single beat then IDLE.
REQ-029 ramstate BUSY or FREE in any RAM state: hold state and wcnt, waits stay high; ERROR: hold state and wcnt, waits high (beat retried), no error propagation.
REQ-030 Outputs not named for the current state default: iwait=dwait=all 1, loads/ramstore/ramaddr/ccsnoopaddr=0, strobes/ccwait/ccinv=0.
REQ-031 Requests deasserted mid-transaction do not abort DWB/C2C/MEMRD/IFETCH; block completes.

Reset
REQ-032 nRST low forces IDLE, wcnt=0, data and instruction pointers = CPUS-1 (first grant goes to index 0), immediately and regardless of CLK, including mid-transfer.
REQ-033 During and after reset until first ARB all outputs equal REQ-030 defaults.

Verification
REQ-034 CPUS=2, WORDS=2: dWEN[0] and iREN[1] together, ramstate ACCESS every cycle -> DWB for 2 beats at daddr[0], then IFETCH with iwait[1]=0 one cycle.
REQ-035 CPUS=4: dREN+cctrans on caches 1 and 3 repeatedly -> grants alternate 1,3,1,3; no cache granted twice while other pending.
REQ-036 CPUS=2: cctrans[0], ccwrite[1]=1 and cctrans[1] after 3 cycles -> ccwait[1]=1 for all snoop cycles, C2C: dload[0]=dstore[1]=0xDEADBEEF, ramWEN=1, both dwait low on ACCESS.
REQ-037 MEMRD with ramstate BUSY,ACCESS,ERROR,ACCESS -> dwait[winner] low exactly on the two ACCESS cycles, wcnt 0->1->2, then IDLE.
REQ-038 nRST pulsed low in second beat of C2C -> IDLE same cycle, all outputs default, next grant to cache 0.
